// File: rtl/golden_nonce_detect.sv
// Golden-nonce detector: queues nonce tags as they enter the hash core and matches each finished digest to its tag.
// Result (found/exhausted) is registered on the digest's strobe edge; no backpressure, overflow/underflow only sets tag_err.
module golden_nonce_detect #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clearCounter,
  input  logic [5:0]   cycle,
  input  logic [31:0]  nonce,
  input  logic         hash_valid,
  input  logic [255:0] hash,
  input  logic [255:0] target,
  input  logic         found_ack,
  output logic         found,
  output logic [31:0]  golden_nonce,
  output logic         exhausted,
  output logic         busy,
  output logic         tag_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [31:0] LAST_NONCE = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_FOUND, S_EXHAUSTED} state_t;

  state_t        state_q;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q;
  logic          found_q, exhausted_q, tag_err_q;
  logic [31:0]   golden_q;

  logic          in_search, push_req, pop_req, push_ok, pop_ok, hit;
  logic [31:0]   head;

  always_comb begin
    in_search = (state_q == S_SEARCH);
    push_req  = in_search && (cycle == 6'd0);
    pop_req   = in_search && hash_valid;
    // pop is resolved before push, so an empty FIFO never forwards the incoming tag
    pop_ok    = pop_req && (cnt_q != '0);
    push_ok   = push_req && ((cnt_q != FULL_CNT) || pop_ok);
    head      = mem_q[rd_q];
    hit       = (hash < target);
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clearCounter) mem_q[wr_q] <= nonce;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      rd_q        <= '0;
      wr_q        <= '0;
      cnt_q       <= '0;
      found_q     <= 1'b0;
      golden_q    <= '0;
      exhausted_q <= 1'b0;
      tag_err_q   <= 1'b0;
    end else if (clearCounter) begin
      state_q     <= S_IDLE;
      rd_q        <= '0;
      wr_q        <= '0;
      cnt_q       <= '0;
      found_q     <= 1'b0;
      golden_q    <= '0;
      exhausted_q <= 1'b0;
      tag_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cycle == 6'd0) state_q <= S_SEARCH;
        end
        S_SEARCH: begin
          if (push_ok) wr_q <= wr_q + 1'b1;
          if (pop_ok)  rd_q <= rd_q + 1'b1;
          if (push_ok && !pop_ok)      cnt_q <= cnt_q + 1'b1;
          else if (pop_ok && !push_ok) cnt_q <= cnt_q - 1'b1;
          if ((pop_req && !pop_ok) || (push_req && !push_ok)) tag_err_q <= 1'b1;
          if (pop_ok) begin
            if (hit) begin
              golden_q <= head;
              found_q  <= 1'b1;
              state_q  <= S_FOUND;
            end else if (head == LAST_NONCE) begin
              exhausted_q <= 1'b1;
              state_q     <= S_EXHAUSTED;
            end
          end
        end
        S_FOUND: begin
          if (found_ack) begin
            found_q <= 1'b0;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            // a hit on the final nonce still ends the search once acknowledged
            if (golden_q == LAST_NONCE) begin
              exhausted_q <= 1'b1;
              state_q     <= S_EXHAUSTED;
            end else begin
              state_q <= S_SEARCH;
            end
          end
        end
        S_EXHAUSTED: ;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign found        = found_q;
  assign golden_nonce = golden_q;
  assign exhausted    = exhausted_q;
  assign tag_err      = tag_err_q;
  assign busy         = (state_q == S_SEARCH);

endmodule

// File: tb/tb_golden_nonce_detect.sv
// Bench for golden_nonce_detect: directed scenarios plus random traffic against a queue-based model.
module tb_golden_nonce_detect;
  localparam int DEPTH = 4;
  localparam logic [255:0] TGT = {4'h8, 252'h0};
  localparam logic [255:0] HLO = TGT - 256'd1;
  localparam logic [255:0] HHI = TGT + 256'd1;
  localparam logic [31:0]  LAST = 32'hFFFF_FFFF;

  logic         clk = 1'b0;
  logic         n_rst, clearCounter, hash_valid, found_ack;
  logic [5:0]   cycle;
  logic [31:0]  nonce;
  logic [255:0] hash, target;
  logic         found, exhausted, busy, tag_err;
  logic [31:0]  golden_nonce;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  golden_nonce_detect #(.DEPTH(DEPTH)) dut (
    .clk(clk), .n_rst(n_rst), .clearCounter(clearCounter), .cycle(cycle),
    .nonce(nonce), .hash_valid(hash_valid), .hash(hash), .target(target),
    .found_ack(found_ack), .found(found), .golden_nonce(golden_nonce),
    .exhausted(exhausted), .busy(busy), .tag_err(tag_err)
  );

  always #5 clk = ~clk;

  // Model: mode 0 idle, 1 searching, 2 holding a result, 3 done
  int          m_mode;
  logic [31:0] mq[$];
  bit          m_found, m_exh, m_err;
  logic [31:0] m_gold;

  always @(posedge clk or negedge n_rst) begin
    logic [31:0] t;
    bit got;
    if (!n_rst || clearCounter) begin
      m_mode = 0; mq.delete(); m_found = 0; m_exh = 0; m_err = 0; m_gold = 0;
    end else begin
      case (m_mode)
        0: if (cycle == 0) m_mode = 1;
        1: begin
          got = 0;
          if (hash_valid) begin
            if (mq.size() == 0) m_err = 1;
            else begin t = mq.pop_front(); got = 1; end
          end
          if (cycle == 0) begin
            if (mq.size() >= DEPTH) m_err = 1;
            else mq.push_back(nonce);
          end
          if (got) begin
            if (hash < target) begin m_gold = t; m_found = 1; m_mode = 2; end
            else if (t == LAST) begin m_exh = 1; m_mode = 3; end
          end
        end
        2: if (found_ack) begin
          m_found = 0; mq.delete();
          if (m_gold == LAST) begin m_exh = 1; m_mode = 3; end
          else m_mode = 1;
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if (found !== m_found || golden_nonce !== m_gold || exhausted !== m_exh ||
          busy !== (m_mode == 1) || tag_err !== m_err) begin
        errors++;
        $display("FAIL model_cmp t=%0t got f=%b g=%h e=%b b=%b te=%b need f=%b g=%h e=%b b=%b te=%b",
                 $time, found, golden_nonce, exhausted, busy, tag_err,
                 m_found, m_gold, m_exh, (m_mode == 1), m_err);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h need %h", name, got, exp);
    end
  endtask

  task automatic cyc(input logic [5:0] c, input logic [31:0] n, input logic hv,
                     input logic [255:0] h, input logic ack, input logic clr);
    cycle = c; nonce = n; hash_valid = hv; hash = h; found_ack = ack; clearCounter = clr;
    @(negedge clk);
  endtask

  function automatic logic [255:0] r256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic start_search();
    cyc(6'd5, 0, 0, 0, 0, 1);
    cyc(6'd0, 0, 0, 0, 0, 0);
    chk("enter_search_busy", {31'd0, busy}, 1);
  endtask

  initial begin
    logic [255:0] h;
    logic [31:0]  n;
    n_rst = 0; clearCounter = 0; cycle = 6'd1; nonce = 0; hash_valid = 0;
    hash = 0; target = TGT; found_ack = 0;
    #2;
    chk("rst_found", {31'd0, found}, 0);
    chk("rst_golden", golden_nonce, 0);
    chk("rst_exh", {31'd0, exhausted}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_tagerr", {31'd0, tag_err}, 0);
    @(negedge clk); @(negedge clk);
    n_rst = 1; cmp_en = 1;

    // push 5,6,7; miss on 5, hit on 6
    cyc(6'd0, 0, 0, 0, 0, 0);
    chk("idle_to_search", {31'd0, busy}, 1);
    cyc(6'd0, 5, 0, 0, 0, 0);
    cyc(6'd0, 6, 0, 0, 0, 0);
    cyc(6'd0, 7, 0, 0, 0, 0);
    cyc(6'd1, 0, 1, HHI, 0, 0);
    chk("miss_found", {31'd0, found}, 0);
    cyc(6'd1, 0, 1, HLO, 0, 0);
    chk("hit_found", {31'd0, found}, 1);
    chk("hit_golden", golden_nonce, 6);
    chk("hit_busy", {31'd0, busy}, 0);
    cyc(6'd1, 0, 0, 0, 1, 0);
    chk("ack_found", {31'd0, found}, 0);
    chk("ack_busy", {31'd0, busy}, 1);
    chk("ack_golden", golden_nonce, 6);
    cyc(6'd1, 0, 1, HLO, 0, 0);
    chk("ack_flushed_tagerr", {31'd0, tag_err}, 1);
    chk("ack_flushed_nohit", {31'd0, found}, 0);
    cyc(6'd5, 0, 0, 0, 0, 1);
    chk("clr_tagerr", {31'd0, tag_err}, 0);
    chk("clr_golden", golden_nonce, 0);

    // last nonce misses -> exhausted, sticky
    start_search();
    cyc(6'd0, LAST, 0, 0, 0, 0);
    cyc(6'd1, 0, 1, HHI, 0, 0);
    chk("exh_set", {31'd0, exhausted}, 1);
    chk("exh_busy", {31'd0, busy}, 0);
    cyc(6'd0, 9, 1, HLO, 0, 0);
    cyc(6'd0, 9, 1, HLO, 1, 0);
    chk("exh_hold", {31'd0, exhausted}, 1);
    chk("exh_nofound", {31'd0, found}, 0);
    chk("exh_noerr", {31'd0, tag_err}, 0);

    // hit on last nonce -> FOUND, then EXHAUSTED after ack
    start_search();
    cyc(6'd0, LAST, 0, 0, 0, 0);
    cyc(6'd1, 0, 1, HLO, 0, 0);
    chk("lasthit_golden", golden_nonce, LAST);
    cyc(6'd1, 0, 0, 0, 1, 0);
    chk("lasthit_exh", {31'd0, exhausted}, 1);
    chk("lasthit_busy", {31'd0, busy}, 0);

    // overflow: five pushes, first four kept in order
    start_search();
    for (int i = 0; i < 5; i++) cyc(6'd0, 10 + i, 0, 0, 0, 0);
    chk("ovf_tagerr", {31'd0, tag_err}, 1);
    for (int i = 0; i < 3; i++) cyc(6'd1, 0, 1, HHI, 0, 0);
    chk("ovf_nohit", {31'd0, found}, 0);
    cyc(6'd1, 0, 1, HLO, 0, 0);
    chk("ovf_fourth", golden_nonce, 13);

    // equality is a miss; push/pop on empty keeps the pushed tag
    start_search();
    cyc(6'd0, 20, 0, 0, 0, 0);
    cyc(6'd1, 0, 1, TGT, 0, 0);
    chk("eq_nohit", {31'd0, found}, 0);
    chk("eq_noerr", {31'd0, tag_err}, 0);
    cyc(6'd0, 21, 1, HLO, 0, 0);
    chk("empty_pp_tagerr", {31'd0, tag_err}, 1);
    chk("empty_pp_nohit", {31'd0, found}, 0);
    cyc(6'd1, 0, 1, HLO, 0, 0);
    chk("empty_pp_kept", golden_nonce, 21);

    // asynchronous reset mid-search
    start_search();
    cyc(6'd0, 30, 0, 0, 0, 0);
    cycle = 6'd1; hash_valid = 0; clearCounter = 0; found_ack = 0;
    #2 n_rst = 0;
    #1;
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_out", {found, exhausted, tag_err} == 3'b0 ? golden_nonce : 32'hDEAD, 0);
    #1 n_rst = 1;
    @(negedge clk);
    cyc(6'd0, 0, 0, 0, 0, 0);
    cyc(6'd0, 31, 0, 0, 0, 0);
    cyc(6'd1, 0, 1, HLO, 0, 0);
    chk("arst_resume", golden_nonce, 31);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      case ($urandom_range(0, 3))
        0: h = TGT;
        1: h = HLO;
        2: h = HHI;
        default: h = r256();
      endcase
      n = ($urandom_range(0, 15) == 0) ? LAST : $urandom;
      if ($urandom_range(0, 79) == 0) begin
        target = r256();
        cyc(6'($urandom), n, 1'($urandom), h, 1'($urandom), 1);
      end else begin
        cyc(($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom_range(1, 63)), n,
            ($urandom_range(0, 2) == 0), (target == TGT) ? h : r256(),
            ($urandom_range(0, 3) == 0), 0);
      end
    end

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/golden_nonce_detect.md
GOLDEN_NONCE_DETECT -- requirements
Module: golden_nonce_detect

Interface
REQ-001 Parameter DEPTH, 4: nonce tag FIFO depth, power of two, 2..16.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 n_rst  in  1  asynchronous active-low reset.
REQ-004 clearCounter  in  1  synchronous clear, active high.
REQ-005 cycle  in  6  SHA round index from the cycle counter.
REQ-006 nonce  in  32  nonce currently entering the hash core, from the nonce counter.
REQ-007 hash_valid  in  1  one-cycle strobe: hash holds a finished digest.
REQ-008 hash  in  256  finished double-SHA digest, MSB = most significant.
REQ-009 target  in  256  difficulty target, held stable while busy.
REQ-010 found_ack  in  1  host acknowledge of golden_nonce.
REQ-011 found  out  1  golden_nonce valid.
REQ-012 golden_nonce  out  32  nonce whose digest met target.
REQ-013 exhausted  out  1  nonce space searched with no hit.
REQ-014 busy  out  1  FSM in SEARCH.
REQ-015 tag_err  out  1  sticky FIFO overflow/underflow flag.

Function
REQ-016 States SHALL be IDLE, SEARCH, FOUND, EXHAUSTED, encoded in one registered state variable.
REQ-017 IDLE -> SEARCH SHALL occur on the first rising edge where cycle == 0 and clearCounter == 0.
REQ-018 In SEARCH, cycle == 0 SHALL push nonce into the tag FIFO (push event).
REQ-019 In SEARCH, hash_valid SHALL pop the FIFO head (pop event) and compare the popped tag's hash, unsigned, against target.
REQ-020 Hit = hash < target, strictly; hash == target SHALL NOT be a hit.
REQ-021 On hit: golden_nonce <= popped tag, found <= 1, state -> FOUND, all on the same edge as the pop.
REQ-022 On miss with popped tag == 32'hFFFFFFFF: exhausted <= 1, state -> EXHAUSTED.
REQ-023 On miss otherwise: state stays SEARCH.
REQ-024 Push and pop on the same edge SHALL both take effect; occupancy SHALL be unchanged; when the FIFO is empty the pushed entry SHALL NOT bypass to the pop.
REQ-025 Push while full (occupancy == DEPTH, no simultaneous pop): push dropped, tag_err <= 1.
REQ-026 Pop while empty: compare suppressed, no state change, tag_err <= 1.
REQ-027 FIFO read/write pointers SHALL wrap modulo DEPTH; occupancy counter SHALL be log2(DEPTH)+1 bits.
REQ-028 FOUND: golden_nonce and found SHALL hold until found_ack; found_ack SHALL clear found, flush the FIFO and return to SEARCH on the next edge.
REQ-029 In FOUND and EXHAUSTED, pushes and pops SHALL be ignored without setting tag_err.
REQ-030 Hit on a popped tag of 32'hFFFFFFFF SHALL take FOUND; after ack the FSM SHALL go to EXHAUSTED, not SEARCH.
REQ-031 EXHAUSTED SHALL persist until clearCounter or reset.
REQ-032 busy SHALL be 1 exactly while state == SEARCH.
REQ-033 found_ack outside FOUND SHALL be ignored.

Reset
REQ-034 n_rst low SHALL immediately force: state IDLE, found 0, golden_nonce 0, exhausted 0, tag_err 0, FIFO empty, pointers 0.
REQ-035 clearCounter high SHALL produce the same values on the next rising edge, taking priority over every other event in that cycle.
REQ-036 Reset or clear mid-SEARCH SHALL discard all in-flight tags; a hash_valid in the following cycles SHALL be treated as pop-while-empty only if the FSM is in SEARCH.

Verification
REQ-037 Reset, push nonces 5, 6, 7, pop with hash > target, then hash < target -> found = 1, golden_nonce = 6, busy = 0.
REQ-038 In FOUND, pulse found_ack -> found = 0, FIFO empty, busy = 1 the next cycle; golden_nonce unchanged.
REQ-039 Push 32'hFFFFFFFF, pop with miss -> exhausted = 1, state EXHAUSTED; further cycle == 0 produces no push.
REQ-040 DEPTH = 4: five pushes with no pop -> tag_err = 1, occupancy 4; pops return the first four nonces in order.
REQ-041 hash == target on a pop -> no hit; then simultaneous push/pop with an empty FIFO -> tag_err = 1, occupancy 1.
REQ-042 Assert n_rst low mid-SEARCH between clock edges -> all outputs 0 before the next edge; resume -> first pop reports the nonce pushed after reset.
